jk_bank_ctrl: RTL and testbench

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

---
 rtl/jk_ctrl_pkg.sv | 20 ++
 rtl/jk_bank.sv | 56 +++++
 rtl/jk_bank_ctrl.sv | 110 +++++++++++
 tb/tb_jk_bank_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_ctrl_pkg : JK operation encodings and controller state type   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MASTER = 2'd1,
    ST_SLAVE  = 2'd2
  } state_t;

endpackage : jk_ctrl_pkg
`default_nettype wire

// File: rtl/jk_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_bank : W-bit master/slave JK register pair                    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module jk_bank
  import jk_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         master_en,
  input  logic         slave_en,
  input  logic [1:0]   op,
  input  logic [W-1:0] mask,
  output logic [W-1:0] qm,
  output logic [W-1:0] q
);

  logic [W-1:0] qm_q, qm_d;
  logic [W-1:0] q_q,  q_d;

  // Master is always computed from the slave value, so unmasked bits track Q.
  always_comb begin
    qm_d = qm_q;
    q_d  = q_q;
    if (master_en) begin
      case (op)
        OP_HOLD: qm_d = q_q;
        OP_CLR:  qm_d = q_q & ~mask;
        OP_SET:  qm_d = q_q | mask;
        OP_TGL:  qm_d = q_q ^ mask;
        default: qm_d = q_q;
      endcase
    end
    if (slave_en) begin
      q_d = qm_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_q <= '0;
      q_q  <= '0;
    end else begin
      qm_q <= qm_d;
      q_q  <= q_d;
    end
  end

  assign qm = qm_q;
  assign q  = q_q;

endmodule : jk_bank
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_bank_ctrl : two-requester round-robin controller for jk_bank  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_mask,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_mask,
  output logic         req1_ready,
  output logic [W-1:0] qm,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         grant_id
);

  state_t       state_q, state_d;
  logic         rr_q, rr_d;
  logic         grant_id_q, grant_id_d;
  logic         done_q, done_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] mask_q, mask_d;
  logic         sel;
  logic         accept;

  // rr_q names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    sel = rr_q;
    if (req0_valid && !req1_valid) begin
      sel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      sel = 1'b1;
    end
  end

  assign req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !sel;
  assign req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid &&  sel;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_id_d = grant_id_q;
    op_d       = op_q;
    mask_d     = mask_q;
    done_d     = (state_q == ST_SLAVE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_MASTER;
          grant_id_d = sel;
          rr_d       = ~sel;
          op_d       = sel ? req1_op   : req0_op;
          mask_d     = sel ? req1_mask : req0_mask;
        end
      end
      ST_MASTER: state_d = ST_SLAVE;
      ST_SLAVE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      grant_id_q <= 1'b0;
      done_q     <= 1'b0;
      op_q       <= OP_HOLD;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_id_q <= grant_id_d;
      done_q     <= done_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
    end
  end

  jk_bank #(
    .W (W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .master_en (state_q == ST_MASTER),
    .slave_en  (state_q == ST_SLAVE),
    .op        (op_q),
    .mask      (mask_q),
    .qm        (qm),
    .q         (q)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign grant_id = grant_id_q;

endmodule : jk_bank_ctrl
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jk_bank_ctrl : directed self-checking bench for jk_bank_ctrl  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_jk_bank_ctrl;
  import jk_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_mask, req1_mask;
  logic       req0_ready, req1_ready;
  logic [7:0] qm, q;
  logic       busy, done, grant_id;

  int checks = 0;
  int errors = 0;

  jk_bank_ctrl #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_mask  (req0_mask),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_mask  (req1_mask),
    .req1_ready (req1_ready),
    .qm         (qm),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] op;
    logic [7:0] mask;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vt [6];
  logic [7:0] exp_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Single-requester command from IDLE through DONE, checking every stage.
  task automatic run_cmd(input logic r, input logic [1:0] op, input logic [7:0] mask,
                         input logic [7:0] prev, input logic [7:0] exp_q);
    int   n;
    logic rdy;
    @(negedge clk);
    if (r) begin
      req1_valid = 1'b1; req1_op = op; req1_mask = mask;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_mask = mask;
    end
    #1;
    n   = 0;
    rdy = r ? req1_ready : req0_ready;
    while (!rdy && n < 8) begin
      @(negedge clk); #1;
      n++;
      rdy = r ? req1_ready : req0_ready;
    end
    check("ready", {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("busy_e0", {31'd0, busy}, 32'd1);
    check("grant_id", {31'd0, grant_id}, {31'd0, r});
    check("qm_e0", {24'd0, qm}, {24'd0, prev});
    @(posedge clk); #1;
    check("qm_e1", {24'd0, qm}, {24'd0, exp_q});
    check("q_e1", {24'd0, q}, {24'd0, prev});
    check("done_e1", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("q_e2", {24'd0, q}, {24'd0, exp_q});
    check("done_e2", {31'd0, done}, 32'd1);
    check("busy_e2", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_after", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    vt[0] = '{r: 1'b0, op: OP_SET,  mask: 8'h0F, exp_q: 8'h0F};
    vt[1] = '{r: 1'b1, op: OP_TGL,  mask: 8'hFF, exp_q: 8'hF0};
    vt[2] = '{r: 1'b0, op: OP_SET,  mask: 8'h00, exp_q: 8'hF0};
    vt[3] = '{r: 1'b1, op: OP_HOLD, mask: 8'hFF, exp_q: 8'hF0};
    vt[4] = '{r: 1'b0, op: OP_CLR,  mask: 8'h30, exp_q: 8'hC0};
    vt[5] = '{r: 1'b1, op: OP_SET,  mask: 8'h30, exp_q: 8'hF0};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = OP_SET; req0_mask = 8'hFF;
    req1_valid = 1'b0; req1_op = OP_HOLD; req1_mask = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_qm", {24'd0, qm}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_gid", {31'd0, grant_id}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    exp_prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      run_cmd(vt[i].r, vt[i].op, vt[i].mask, exp_prev, vt[i].exp_q);
      exp_prev = vt[i].exp_q;
    end

    // Both valid, last served = 1: requester 0 first, then 1, three cycles apart.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_CLR; req0_mask = 8'hF0;
    req1_valid = 1'b1; req1_op = OP_SET; req1_mask = 8'h01;
    #1;
    check("rr_ready0", {31'd0, req0_ready}, 32'd1);
    check("rr_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    check("rr_gid0", {31'd0, grant_id}, 32'd0);
    check("rr_busy_ready0", {31'd0, req0_ready}, 32'd0);
    n = 0;
    while (!req1_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("rr_spacing", n + 1, 32'd3);
    check("rr_q_first", {24'd0, q}, 32'h00);
    check("rr_ready0_second", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_gid1", {31'd0, grant_id}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rr_q_second", {24'd0, q}, 32'h01);
    check("rr_done", {31'd0, done}, 32'd1);

    // Inputs changed while busy are ignored.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_TGL; req0_mask = 8'h0F;
    #1;
    check("ign_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_op = OP_SET; req0_mask = 8'hFF;
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("ign_ready_busy", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("ign_qm", {24'd0, qm}, 32'h0E);
    @(posedge clk); #1;
    check("ign_q", {24'd0, q}, 32'h0E);

    // Valid withdrawn before any edge takes no command.
    @(negedge clk);
    req1_valid = 1'b1; req1_op = OP_TGL; req1_mask = 8'hFF;
    #2;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("wd_busy", {31'd0, busy}, 32'd0);
    check("wd_q", {24'd0, q}, 32'h0E);

    // Reset asserted in SLAVE aborts the command.
    @(negedge clk);
    req1_valid = 1'b1; req1_op = OP_SET; req1_mask = 8'hF0;
    #1;
    check("ab_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("ab_qm", {24'd0, qm}, 32'hFE);
    check("ab_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = OP_SET; req0_mask = 8'h55;
    #1;
    check("ab_q", {24'd0, q}, 32'd0);
    check("ab_qm0", {24'd0, qm}, 32'd0);
    check("ab_busy0", {31'd0, busy}, 32'd0);
    check("ab_ready0", {31'd0, req0_ready}, 32'd0);
    check("ab_gid", {31'd0, grant_id}, 32'd0);
    @(posedge clk); #1;
    check("ab_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_op = OP_TGL; req1_mask = 8'hFF;
    #1;
    check("ab_rr_ready0", {31'd0, req0_ready}, 32'd1);
    check("ab_rr_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("ab_rr_gid", {31'd0, grant_id}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("ab_rr_q", {24'd0, q}, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jk_bank_ctrl
`default_nettype wire
